// File: rtl/id_ex_issue_stage.sv
// rtl/id_ex_issue_stage.sv - ID/EX issue stage with RAW bubble insertion, wb tagging and forwarding (optional ISSUE_PERF_CNT_EN perf counters)
module id_ex_issue_stage #(
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [5:0]  BUBBLE_OP    = 6'h3F,
  parameter int          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       rf_a,
  input  logic [31:0]       rf_b,
  output logic              alu_load,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  output logic [5:0]        alu_opcode,
  input  logic [31:0]       alu_result,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_stall,
  output logic [CNT_W-1:0]  perf_drain
`endif
);

  localparam int IDLE_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [IDLE_W-1:0] DRAIN_LAST = IDLE_W'(DRAIN_CYCLES - 1);

  typedef enum logic {S_EMPTY, S_PEND} state_t;

  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;

  logic              hazard;
  logic [31:0]       fwd_a, fwd_b;
  logic              hazard_bubble, drain_bubble;

  // RAW hazard against the instruction still sitting in the ALU operand registers
  assign hazard = (state_q == S_PEND) && in_valid && (pend_rd_q != 5'd0) &&
                  ((in_rs1 == pend_rd_q) || (in_rs2 == pend_rd_q));

  // Operand bypass from the result currently on the writeback bus
  assign fwd_a = (wb_valid_q && (wb_rd_q != 5'd0) && (wb_rd_q == in_rs1)) ? alu_result : rf_a;
  assign fwd_b = (wb_valid_q && (wb_rd_q != 5'd0) && (wb_rd_q == in_rs2)) ? alu_result : rf_b;

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = alu_result;

  // Next-state and issue decision: issue, hazard bubble, drain bubble or idle
  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_rd_d     = pend_rd_q;
    idle_d        = idle_q;
    in_ready      = 1'b0;
    alu_load      = 1'b0;
    alu_opcode    = BUBBLE_OP;
    alu_a         = 32'd0;
    alu_b         = 32'd0;
    hazard_bubble = 1'b0;
    drain_bubble  = 1'b0;
    if (!rst) begin
      if (hazard) begin
        alu_load      = 1'b1;
        hazard_bubble = 1'b1;
        state_d       = S_EMPTY;
        pend_valid_d  = 1'b0;
        pend_rd_d     = 5'd0;
        idle_d        = '0;
      end else begin
        in_ready = 1'b1;
        if (in_valid) begin
          alu_load     = 1'b1;
          alu_opcode   = in_opcode;
          alu_a        = fwd_a;
          alu_b        = fwd_b;
          pend_valid_d = 1'b1;
          pend_rd_d    = in_rd;
          state_d      = S_PEND;
          idle_d       = '0;
        end else if (state_q == S_PEND) begin
          if (idle_q == DRAIN_LAST) begin
            alu_load     = 1'b1;
            drain_bubble = 1'b1;
            state_d      = S_EMPTY;
            pend_valid_d = 1'b0;
            pend_rd_d    = 5'd0;
            idle_d       = '0;
          end else begin
            idle_d = idle_q + IDLE_W'(1);
          end
        end
      end
    end
  end

  // State, pending-instruction tag and idle counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_EMPTY;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= 5'd0;
      idle_q       <= '0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      idle_q       <= idle_d;
    end
  end

  // Each load computes the previously held instr, so tag its result one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
    end else if (alu_load) begin
      wb_valid_q <= pend_valid_q;
      wb_rd_q    <= pend_rd_q;
    end else begin
      wb_valid_q <= 1'b0;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  logic [CNT_W-1:0] perf_stall_q, perf_drain_q;

  // Saturating counters of hazard and drain bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_drain_q <= '0;
    end else begin
      if (hazard_bubble && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + CNT_W'(1);
      if (drain_bubble && (perf_drain_q != '1)) perf_drain_q <= perf_drain_q + CNT_W'(1);
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_drain = perf_drain_q;
`else
  logic unused_perf;
  assign unused_perf = hazard_bubble ^ drain_bubble;
`endif

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// tb/tb_id_ex_issue_stage.sv - self-checking bench for id_ex_issue_stage
module tb_id_ex_issue_stage;

  localparam logic [5:0] OP_ADD = 6'd0, OP_SUB = 6'd1, OP_AND = 6'd2,
                         OP_OR  = 6'd3, OP_SLT = 6'd4, OP_MUL = 6'd5;
  localparam logic [5:0] BUB = 6'h3F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_opcode = 6'd0;
  logic [4:0]  in_rs1 = 5'd0, in_rs2 = 5'd0, in_rd = 5'd0;
  logic [31:0] rf_a, rf_b;
  logic        alu_load;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] perf_stall, perf_drain;
`endif

  int checks = 0;
  int errors = 0;

  id_ex_issue_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .rf_a(rf_a), .rf_b(rf_b),
    .alu_load(alu_load), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef ISSUE_PERF_CNT_EN
    , .perf_stall(perf_stall), .perf_drain(perf_drain)
`endif
  );

  always #5 clk = ~clk;

  // Register file (no write-through) and downstream ALU model
  logic [31:0] regs [32];
  assign rf_a = (in_rs1 == 5'd0) ? 32'd0 : regs[in_rs1];
  assign rf_b = (in_rs2 == 5'd0) ? 32'd0 : regs[in_rs2];

  always @(posedge clk) begin
    if (!rst && wb_valid && wb_rd != 5'd0) regs[wb_rd] <= wb_data;
  end

  logic [31:0] opa_q, opb_q;
  logic [5:0]  op_q;

  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_MUL:  return a * b;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q <= 32'd0; opb_q <= 32'd0; op_q <= BUB; alu_result <= 32'd0;
    end else if (alu_load) begin
      alu_result <= alu_f(op_q, opa_q, opb_q);
      opa_q <= alu_a; opb_q <= alu_b; op_q <= alu_opcode;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected {rd, data} writebacks
  logic [36:0] sb [$];

  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_wb", {27'd0, wb_rd}, 32'hFFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
        chk("wb_data", wb_data, e[31:0]);
      end
    end
  end

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs1, rs2, rd;
    int          idle;
    logic [31:0] exp_a, exp_b, exp_data;
    int          exp_stall;
  } vec_t;

  vec_t vecs [11];

  task automatic issue(input logic [5:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] ea, input logic [31:0] eb,
                       input logic [31:0] ed, input int estall);
    int stalls;
    bit ok;
    stalls = 0;
    ok = 0;
    in_valid = 1'b1; in_opcode = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
      stalls++;
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    chk("stall_cycles", stalls, estall);
    chk("load_on_issue", {31'd0, alu_load}, 32'd1);
    chk("alu_opcode", {26'd0, alu_opcode}, {26'd0, op});
    chk("alu_a", alu_a, ea);
    chk("alu_b", alu_b, eb);
    sb.push_back({rd, ed});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < 32; r++) regs[r] = 32'd0;
    regs[10] = 32'd5;  regs[11] = 32'd3;  regs[12] = 32'd9;  regs[13] = 32'd4;
    regs[14] = 32'hC;  regs[15] = 32'hFFFF_FFFD; regs[16] = 32'd7; regs[17] = 32'd2;

    vecs[0]  = '{OP_ADD, 5'd10, 5'd11, 5'd1, 0, 32'd5, 32'd3, 32'd8, 0};
    vecs[1]  = '{OP_SUB, 5'd12, 5'd13, 5'd2, 3, 32'd9, 32'd4, 32'd5, 0};
    vecs[2]  = '{OP_ADD, 5'd10, 5'd11, 5'd1, 0, 32'd5, 32'd3, 32'd8, 0};
    vecs[3]  = '{OP_AND, 5'd1,  5'd14, 5'd3, 3, 32'd8, 32'hC, 32'd8, 1};
    vecs[4]  = '{OP_MUL, 5'd15, 5'd16, 5'd4, 0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 0};
    vecs[5]  = '{OP_SLT, 5'd4,  5'd17, 5'd5, 3, 32'hFFFF_FFEB, 32'd2, 32'd1, 1};
    vecs[6]  = '{OP_OR,  5'd3,  5'd5,  5'd6, 0, 32'd8, 32'd1, 32'd9, 0};
    vecs[7]  = '{OP_SUB, 5'd6,  5'd1,  5'd7, 0, 32'd9, 32'd8, 32'd1, 1};
    vecs[8]  = '{OP_ADD, 5'd7,  5'd7,  5'd8, 3, 32'd1, 32'd1, 32'd2, 1};
    vecs[9]  = '{OP_ADD, 5'd10, 5'd11, 5'd0, 0, 32'd5, 32'd3, 32'd8, 0};
    vecs[10] = '{OP_AND, 5'd0,  5'd14, 5'd9, 3, 32'd0, 32'hC, 32'd0, 0};

    // Reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_alu_load", {31'd0, alu_load}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_alu_load", {31'd0, alu_load}, 32'd0);
    chk("idle_opcode", {26'd0, alu_opcode}, {26'd0, BUB});
    chk("idle_alu_a", alu_a, 32'd0);
    @(posedge clk);
    #1;

    // Table-driven stream
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_data, vecs[i].exp_stall);
      repeat (vecs[i].idle) begin @(posedge clk); #1; end
    end

    // Drain timing: bubble on the second idle cycle, result tagged the cycle after
    issue(OP_ADD, 5'd10, 5'd10, 5'd23, 32'd5, 32'd5, 32'd10, 0);
    @(negedge clk);
    chk("drain_c1_load", {31'd0, alu_load}, 32'd0);
    chk("drain_c1_wb", {31'd0, wb_valid}, 32'd0);
    @(negedge clk);
    chk("drain_c2_load", {31'd0, alu_load}, 32'd1);
    chk("drain_c2_opcode", {26'd0, alu_opcode}, {26'd0, BUB});
    chk("drain_c2_a", alu_a, 32'd0);
    chk("drain_c2_b", alu_b, 32'd0);
    @(negedge clk);
    chk("drain_c3_wb", {31'd0, wb_valid}, 32'd1);
    @(negedge clk);
    chk("drain_c4_wb", {31'd0, wb_valid}, 32'd0);
    @(posedge clk);
    #1;

`ifdef ISSUE_PERF_CNT_EN
    chk("perf_stall", {16'd0, perf_stall}, 32'd4);
    chk("perf_drain", {16'd0, perf_drain}, 32'd6);
`endif

    // Reset mid-stream while a result is being tagged
    issue(OP_ADD, 5'd10, 5'd11, 5'd20, 32'd5, 32'd3, 32'd8, 0);
    issue(OP_SUB, 5'd12, 5'd13, 5'd21, 32'd9, 32'd4, 32'd5, 0);
    rst = 1'b1;
    #1;
    chk("midrst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_alu_load", {31'd0, alu_load}, 32'd0);
    sb.delete();
`ifdef ISSUE_PERF_CNT_EN
    chk("perf_stall_rst", {16'd0, perf_stall}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("postrst_no_wb", {31'd0, wb_valid}, 32'd0);
      chk("postrst_no_load", {31'd0, alu_load}, 32'd0);
    end
    @(posedge clk);
    #1;
    issue(OP_ADD, 5'd10, 5'd11, 5'd22, 32'd5, 32'd3, 32'd8, 0);
    repeat (6) begin @(posedge clk); #1; end
    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
